fp_alu_seq: RTL and testbench
=============================

# fp_alu_seq

Sequential, parametrised floating-point ALU performing add, subtract and multiply on operands of `1+EXP_W+MAN_W` bits, using IEEE-754-style packing. It is the multi-cycle successor to the combinational add/multiply ALU. It gains a valid/ready handshake on both sides, a subtract mode, exception flags and configurable format width, and it sits between the operand register file and the writeback stage. Only one operation is in flight at a time. The multiplier is iterative (shift-add) to save area.

## Interface
Parameters:
- `EXP_W`, default 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 23: stored mantissa width; hidden bit implicit.

Ports (W = 1+EXP_W+MAN_W):
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: operands and op are valid.
- `in_ready`, output, 1: block is idle and accepts an op.
- `A`, input, W: operand A.
- `B`, input, W: operand B.
- `Op`, input, 2: 00 add, 01 sub (A-B), 10 mul, 11 reserved.
- `out_valid`, output, 1: result and flags are valid.
- `out_ready`, input, 1: consumer takes the result.
- `Out`, output, W: result.
- `flags`, output, 3: {invalid, overflow, underflow}.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - UNPACK
  - EXEC
  - NORM
  - DONE: `out_valid`=1.
- Accept: `in_valid && in_ready` at an edge latches A, B and Op, then moves to UNPACK. Inputs may change afterwards.
- UNPACK:
  - Split sign, exponent and mantissa; restore the hidden bit.
  - Exp==0 inputs flush to signed zero (no denormals).
  - For sub, invert the sign of B.
- EXEC, add/sub: 1 cycle.
  - Swap so the larger magnitude comes first.
  - Right-shift the smaller mantissa by the exponent difference (differences of MAN_W+2 or more give 0).
  - Add or subtract magnitudes in MAN_W+2 bits.
- EXEC, mul: exactly MAN_W+1 cycles.
  - One shift-add step per cycle into a 2*(MAN_W+1)-bit product.
  - Exponent = eA+eB-bias, computed in EXP_W+2 signed bits.
  - Sign = sA^sB.
- NORM: 1 cycle.
  - Leading-one detect, then shift so the hidden bit is at position MAN_W, adjusting the exponent.
  - Rounding is truncation (toward zero).
- Exact zero result: Out=+0 (0x0 pattern), no flags.
- Exponent ≥ 2^EXP_W-1 after NORM: Out = signed infinity (exp all ones, mantissa 0), overflow=1.
- Exponent ≤ 0 after NORM: Out = signed zero, underflow=1.
- Any operand with exp all ones, or Op=11: Out = canonical NaN (sign 0, exp all ones, mantissa MSB 1, rest 0), invalid=1. EXEC and NORM still run, so latency is unchanged.
- DONE holds Out and flags stable until `out_ready`=1. At that edge the block returns to IDLE.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `Out`=0, `flags`=0, state IDLE. Reset is asynchronous, so it aborts any op immediately and the partial result is discarded.
- Accept at edge T:
  - Add/sub: `out_valid` rises after edge T+3.
  - Mul: `out_valid` rises after edge T+MAN_W+3 (T+26 at defaults).
- `in_ready` is 0 from the edge after accept until the edge at which DONE is consumed. It is combinational from state only, with no combinational path from `out_ready`.
- No new op is accepted in the same cycle a result is consumed; the earliest re-accept is one cycle later.
- `out_valid` never drops without `out_ready`. Out and flags are registered outputs.
- `in_valid` asserted while busy is ignored (not queued).

## Test plan
- Add: A=0x3F800000 (1.0), B=0x40000000 (2.0), Op=00 → Out=0x40400000 (3.0), flags=000, `out_valid` 3 cycles after accept.
- Mul: A=0x3FC00000 (1.5), B=0x40200000 (2.5), Op=10 → Out=0x40700000 (3.75), `out_valid` exactly 26 cycles after accept; `in_ready`=0 throughout.
- Sub/zero and flush:
  - A=B=0x3F800000, Op=01 → Out=0x00000000, flags=000.
  - A=0x00000001 (denormal), B=0x3F800000, Op=00 → Out=0x3F800000.
- Exceptions:
  - A=B=0x7F000000, Op=10 → Out=0x7F800000, overflow=1.
  - A=B=0x00800000, Op=10 → Out=0x00000000, underflow=1.
  - A=0x7F800000, Op=00 → Out=0x7FC00000, invalid=1.
  - Op=11 → Out=0x7FC00000, invalid=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → Out stable; `in_ready`=0; a new `in_valid` pulse is ignored; after the release cycle, `in_ready`=1.
- Reset mid-mul: assert `rst` 10 cycles into a mul → `out_valid`=0 and `in_ready`=1 immediately. A following add (1.0+2.0) completes normally with 0x40400000.

Source files
------------

// File: rtl/fp_alu_seq.sv
// Multi-cycle FP add/sub/mul, one op in flight; add/sub out_valid 3 edges after accept, mul MAN_W+3.
// in_ready only in IDLE; result held in DONE until out_ready, busy-time in_valid is dropped.
module fp_alu_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   A,
   input  logic [EXP_W+MAN_W:0]   B,
   input  logic [1:0]             Op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   Out,
   output logic [2:0]             flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int XW = EXP_W + 2;
   localparam int PW = 2 * (MAN_W + 1);
   localparam int CW = $clog2(MAN_W + 2);
   localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
   localparam logic [EXP_W-1:0]        SHIFT_LIM = EXP_W'(MAN_W + 2);
   localparam logic signed [XW-1:0]    BIAS      = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [XW-1:0]    EXP_MAX   = XW'((1 << EXP_W) - 1);

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_EXEC, S_NORM, S_DONE} state_t;

   state_t                r_state;
   logic [W-1:0]          r_a, r_b;
   logic [1:0]            r_op;
   logic                  r_sa, r_sb, r_sign, r_inv;
   logic [EXP_W-1:0]      r_ea, r_eb;
   logic [MAN_W:0]        r_ma, r_mb;
   logic [PW-1:0]         r_prod;
   logic [CW-1:0]         r_cnt;
   logic signed [XW-1:0]  r_exp;
   logic [MAN_W+1:0]      r_mag;
   logic [W-1:0]          r_out;
   logic [2:0]            r_flags;

   // Unpack: exp==0 flushes to signed zero, hidden bit restored otherwise.
   logic [EXP_W-1:0] w_ea, w_eb;
   logic             w_za, w_zb, w_inv;
   logic [MAN_W:0]   w_ma, w_mb;

   assign w_ea  = r_a[W-2:MAN_W];
   assign w_eb  = r_b[W-2:MAN_W];
   assign w_za  = (w_ea == '0);
   assign w_zb  = (w_eb == '0);
   assign w_ma  = w_za ? '0 : {1'b1, r_a[MAN_W-1:0]};
   assign w_mb  = w_zb ? '0 : {1'b1, r_b[MAN_W-1:0]};
   assign w_inv = (w_ea == EXP_ONES) || (w_eb == EXP_ONES) || (r_op == 2'b11);

   logic                w_a_big, w_s_big, w_s_sml;
   logic [EXP_W-1:0]    w_e_big, w_e_sml, w_ediff;
   logic [MAN_W:0]      w_m_big, w_m_sml;
   logic [MAN_W+1:0]    w_aligned, w_sum, w_padd;

   assign w_a_big   = {r_ea, r_ma} >= {r_eb, r_mb};
   assign w_e_big   = w_a_big ? r_ea : r_eb;
   assign w_e_sml   = w_a_big ? r_eb : r_ea;
   assign w_m_big   = w_a_big ? r_ma : r_mb;
   assign w_m_sml   = w_a_big ? r_mb : r_ma;
   assign w_s_big   = w_a_big ? r_sa : r_sb;
   assign w_s_sml   = w_a_big ? r_sb : r_sa;
   assign w_ediff   = w_e_big - w_e_sml;
   assign w_aligned = (w_ediff >= SHIFT_LIM) ? '0 : ({1'b0, w_m_sml} >> w_ediff);
   assign w_sum     = (w_s_big == w_s_sml) ? ({1'b0, w_m_big} + w_aligned)
                                           : ({1'b0, w_m_big} - w_aligned);

   // Right-shifting multiplier: low half starts as A's mantissa and is consumed LSB first.
   assign w_padd = {1'b0, r_prod[PW-1:MAN_W+1]} + (r_prod[0] ? {1'b0, r_mb} : '0);

   logic [MAN_W+1:0]      w_src;
   logic [CW-1:0]         w_pos, w_lsh;
   logic                  w_top;
   logic [MAN_W-1:0]      w_frac;
   logic signed [XW-1:0]  w_nexp;

   assign w_src = (r_op == 2'b10) ? r_prod[PW-1:MAN_W] : r_mag;

   always_comb begin
      w_pos = '0;
      for (int i = 0; i <= MAN_W + 1; i++) begin
         if (w_src[i]) w_pos = CW'(i);
      end
   end

   assign w_top  = w_src[MAN_W+1];
   assign w_lsh  = CW'(MAN_W) - w_pos;
   assign w_frac = w_top ? w_src[MAN_W:1] : MAN_W'(w_src << w_lsh);
   assign w_nexp = w_top ? (r_exp + XW'(1)) : (r_exp - $signed(XW'(w_lsh)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_sign  <= 1'b0;
         r_inv   <= 1'b0;
         r_ea    <= '0;
         r_eb    <= '0;
         r_ma    <= '0;
         r_mb    <= '0;
         r_prod  <= '0;
         r_cnt   <= '0;
         r_exp   <= '0;
         r_mag   <= '0;
         r_out   <= '0;
         r_flags <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_op    <= Op;
                  r_state <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               r_sa    <= r_a[W-1];
               r_sb    <= r_b[W-1] ^ (r_op == 2'b01);
               r_ea    <= w_ea;
               r_eb    <= w_eb;
               r_ma    <= w_ma;
               r_mb    <= w_mb;
               r_inv   <= w_inv;
               r_prod  <= {{(MAN_W+1){1'b0}}, w_ma};
               r_cnt   <= '0;
               r_exp   <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;
               r_sign  <= r_a[W-1] ^ r_b[W-1];
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (r_op == 2'b10) begin
                  r_prod <= {w_padd, r_prod[MAN_W:1]};
                  r_cnt  <= r_cnt + CW'(1);
                  if (r_cnt == CW'(MAN_W)) r_state <= S_NORM;
               end else begin
                  r_mag   <= w_sum;
                  r_exp   <= $signed({2'b00, w_e_big});
                  r_sign  <= w_s_big;
                  r_state <= S_NORM;
               end
            end
            S_NORM: begin
               if (r_inv) begin
                  r_out   <= {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                  r_flags <= 3'b100;
               end else if (w_src == '0) begin
                  r_out   <= '0;
                  r_flags <= 3'b000;
               end else if (w_nexp >= EXP_MAX) begin
                  r_out   <= {r_sign, EXP_ONES, {MAN_W{1'b0}}};
                  r_flags <= 3'b010;
               end else if (w_nexp[XW-1] || (w_nexp == '0)) begin
                  r_out   <= {r_sign, {(W-1){1'b0}}};
                  r_flags <= 3'b001;
               end else begin
                  r_out   <= {r_sign, w_nexp[EXP_W-1:0], w_frac};
                  r_flags <= 3'b000;
               end
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign Out       = r_out;
   assign flags     = r_flags;
endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed-vector bench for fp_alu_seq at default single-precision format.
module tb_fp_alu_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [1:0]  op = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] res_out;
   logic [2:0]  res_flags;

   int checks = 0;
   int errors = 0;

   fp_alu_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .Op(op), .out_valid(out_valid), .out_ready(out_ready),
      .Out(res_out), .flags(res_flags)
   );

   always #5 clk = ~clk;

   // Drives one op from idle, waits (bounded) for out_valid, captures and consumes the result.
   task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                        output logic [31:0] r, output logic [2:0] f, output int lat,
                        output logic rdy_seen);
      a = ia; b = ib; op = iop; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_seen = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      r = res_out;
      f = res_flags;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (res_out !== 32'h0) begin errors++; $display("FAIL reset_out got %h exp 00000000", res_out); end
      checks++; if (res_flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", res_flags); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      logic [31:0] r; logic [2:0] f; int lat; logic rs;
      do_op(32'h3F800000, 32'h40000000, 2'b00, r, f, lat, rs);
      checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL add_out got %h exp 40400000", r); end
      checks++; if (f !== 3'b000) begin errors++; $display("FAIL add_flags got %b exp 000", f); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d exp 3", lat); end
   endtask

   task automatic test_sub();
      logic [31:0] r; logic [2:0] f; int lat; logic rs;
      do_op(32'h3F800000, 32'h3F800000, 2'b01, r, f, lat, rs);
      checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL sub_zero_out got %h exp 00000000", r); end
      checks++; if (f !== 3'b000) begin errors++; $display("FAIL sub_zero_flags got %b exp 000", f); end
      do_op(32'h40400000, 32'h3F800000, 2'b01, r, f, lat, rs);
      checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL sub_3m1 got %h exp 40000000", r); end
      do_op(32'h3F800000, 32'h40400000, 2'b01, r, f, lat, rs);
      checks++; if (r !== 32'hC0000000) begin errors++; $display("FAIL sub_1m3 got %h exp C0000000", r); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL sub_latency got %0d exp 3", lat); end
   endtask

   task automatic test_flush();
      logic [31:0] r; logic [2:0] f; int lat; logic rs;
      do_op(32'h00000001, 32'h3F800000, 2'b00, r, f, lat, rs);
      checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL flush_out got %h exp 3F800000", r); end
      checks++; if (f !== 3'b000) begin errors++; $display("FAIL flush_flags got %b exp 000", f); end
   endtask

   task automatic test_mul();
      logic [31:0] r; logic [2:0] f; int lat; logic rs;
      do_op(32'h3FC00000, 32'h40200000, 2'b10, r, f, lat, rs);
      checks++; if (r !== 32'h40700000) begin errors++; $display("FAIL mul_out got %h exp 40700000", r); end
      checks++; if (f !== 3'b000) begin errors++; $display("FAIL mul_flags got %b exp 000", f); end
      checks++; if (lat !== 26) begin errors++; $display("FAIL mul_latency got %0d exp 26", lat); end
      checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy got %b exp 0", rs); end
      do_op(32'hBFC00000, 32'h40200000, 2'b10, r, f, lat, rs);
      checks++; if (r !== 32'hC0700000) begin errors++; $display("FAIL mul_neg_out got %h exp C0700000", r); end
   endtask

   task automatic test_exceptions();
      logic [31:0] r; logic [2:0] f; int lat; logic rs;
      do_op(32'h7F000000, 32'h7F000000, 2'b10, r, f, lat, rs);
      checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL ovf_out got %h exp 7F800000", r); end
      checks++; if (f !== 3'b010) begin errors++; $display("FAIL ovf_flags got %b exp 010", f); end
      do_op(32'h00800000, 32'h00800000, 2'b10, r, f, lat, rs);
      checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL unf_out got %h exp 00000000", r); end
      checks++; if (f !== 3'b001) begin errors++; $display("FAIL unf_flags got %b exp 001", f); end
      do_op(32'h7F800000, 32'h3F800000, 2'b00, r, f, lat, rs);
      checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL inf_out got %h exp 7FC00000", r); end
      checks++; if (f !== 3'b100) begin errors++; $display("FAIL inf_flags got %b exp 100", f); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL inf_latency got %0d exp 3", lat); end
      do_op(32'h3F800000, 32'h40000000, 2'b11, r, f, lat, rs);
      checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL op11_out got %h exp 7FC00000", r); end
      checks++; if (f !== 3'b100) begin errors++; $display("FAIL op11_flags got %b exp 100", f); end
   endtask

   task automatic test_back_to_back();
      int lat;
      a = 32'h3F800000; b = 32'h40000000; op = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      a = 32'h40400000; b = 32'h3F800000; op = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done got %b exp 0", in_ready); end
      checks++; if (res_out !== 32'h40400000) begin errors++; $display("FAIL b2b_first got %h exp 40400000", res_out); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %b exp 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accepted got %b exp 0", in_ready); end
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency got %0d exp 3", lat); end
      checks++; if (res_out !== 32'h40000000) begin errors++; $display("FAIL b2b_second got %h exp 40000000", res_out); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int lat;
      a = 32'h3F800000; b = 32'h3F800000; op = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      for (int k = 0; k < 5; k++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", k, out_valid); end
         checks++; if (res_out !== 32'h40000000) begin errors++; $display("FAIL bp_out[%0d] got %h exp 40000000", k, res_out); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", k, in_ready); end
         if (k == 1) begin
            a = 32'h40400000; b = 32'h40400000; op = 2'b10; in_valid = 1'b1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pulse_ignored got %b exp 1", in_ready); end
   endtask

   task automatic test_reset_mid_mul();
      logic [31:0] r; logic [2:0] f; int lat; logic rs;
      a = 32'h3FC00000; b = 32'h40200000; op = 2'b10; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmul_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmul_ready got %b exp 1", in_ready); end
      checks++; if (res_out !== 32'h0) begin errors++; $display("FAIL rstmul_out got %h exp 00000000", res_out); end
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(32'h3F800000, 32'h40000000, 2'b00, r, f, lat, rs);
      checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL rstmul_add got %h exp 40400000", r); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL rstmul_add_latency got %0d exp 3", lat); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_flush();
      test_mul();
      test_exceptions();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_mul();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
